// File: rtl/wb_arbiter_pkg.sv
// Shared widths and packed FIFO entry layout for the writeback arbiter.
// Entry layout, MSB to LSB: {pc, rd_en, rd_idx, wdata}.
package wb_arbiter_pkg;

    localparam int DEF_XLEN          = 32;
    localparam int DEF_REG_IDX_WIDTH = 5;
    localparam int DEF_PC_WIDTH      = 32;

    function automatic int wb_entry_width(input int pc_w, input int idx_w, input int x_w);
        return pc_w + 1 + idx_w + x_w;
    endfunction

    function automatic int wb_wdata_lsb();
        return 0;
    endfunction

    function automatic int wb_rd_idx_lsb(input int x_w);
        return x_w;
    endfunction

    function automatic int wb_rd_en_bit(input int x_w, input int idx_w);
        return x_w + idx_w;
    endfunction

    function automatic int wb_pc_lsb(input int x_w, input int idx_w);
        return x_w + idx_w + 1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small per-source result FIFO: registered storage, occupancy count, synchronous flush.
// Head is read combinationally from storage, so a push is never visible the same cycle.
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    // Fullness is judged on the pre-pop count: a full FIFO refuses even while popping.
    assign do_push = push & (count != FULL_CNT) & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: buffers NUM_SRC producer results and round-robins the FIFO heads
// onto a single registered regfile write / retire port.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_SRC       = 2,
    parameter int FIFO_DEPTH    = 2,
    parameter int XLEN          = DEF_XLEN,
    parameter int REG_IDX_WIDTH = DEF_REG_IDX_WIDTH,
    parameter int PC_WIDTH      = DEF_PC_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush_i,
    input  logic [NUM_SRC-1:0]               src_valid_i,
    output logic [NUM_SRC-1:0]               src_ready_o,
    input  logic [NUM_SRC*PC_WIDTH-1:0]      src_pc_i,
    input  logic [NUM_SRC-1:0]               src_rd_en_i,
    input  logic [NUM_SRC*REG_IDX_WIDTH-1:0] src_rd_idx_i,
    input  logic [NUM_SRC*XLEN-1:0]          src_rd_wdata_i,
    output logic                             wb_valid_o,
    output logic [PC_WIDTH-1:0]              wb_pc_o,
    output logic                             wb_rd_en_o,
    output logic [REG_IDX_WIDTH-1:0]         wb_rd_idx_o,
    output logic [XLEN-1:0]                  wb_rd_wdata_o,
    output logic [$clog2(NUM_SRC)-1:0]       wb_src_o
);

    localparam int SRC_W     = $clog2(NUM_SRC);
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W   = wb_entry_width(PC_WIDTH, REG_IDX_WIDTH, XLEN);
    localparam int WDATA_LSB = wb_wdata_lsb();
    localparam int IDX_LSB   = wb_rd_idx_lsb(XLEN);
    localparam int EN_BIT    = wb_rd_en_bit(XLEN, REG_IDX_WIDTH);
    localparam int PC_LSB    = wb_pc_lsb(XLEN, REG_IDX_WIDTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [NUM_SRC-1:0]              push;
    logic [NUM_SRC-1:0]              pop;
    logic [NUM_SRC-1:0]              fifo_empty;
    logic [NUM_SRC-1:0]              req;
    logic [NUM_SRC-1:0][ENTRY_W-1:0] fifo_din;
    logic [NUM_SRC-1:0][ENTRY_W-1:0] fifo_dout;
    logic [NUM_SRC-1:0][CNT_W-1:0]   fifo_cnt;

    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   grant_id;
    logic               grant_vld;
    logic               grant_fire;
    logic [ENTRY_W-1:0] head;
    logic               head_rd_en;
    logic [REG_IDX_WIDTH-1:0] head_rd_idx;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        assign fifo_din[k] = {src_pc_i[k*PC_WIDTH +: PC_WIDTH],
                              src_rd_en_i[k],
                              src_rd_idx_i[k*REG_IDX_WIDTH +: REG_IDX_WIDTH],
                              src_rd_wdata_i[k*XLEN +: XLEN]};
        assign src_ready_o[k] = (fifo_cnt[k] != FULL_CNT);
        assign push[k]        = src_valid_i[k] & src_ready_o[k] & ~flush_i;
        assign pop[k]         = grant_fire & (grant_id == SRC_W'(k));
        assign req[k]         = ~fifo_empty[k];

        wb_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush_i),
            .push  (push[k]),
            .pop   (pop[k]),
            .wdata (fifo_din[k]),
            .rdata (fifo_dout[k]),
            .empty (fifo_empty[k]),
            .count (fifo_cnt[k])
        );
    end

    // Scan upward from the last winner so every requester waits at most NUM_SRC-1 grants.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_id  = rr_ptr;
        idx       = 0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_SRC;
            if (!grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant_id  = SRC_W'(idx);
            end
        end
    end

    assign grant_fire  = grant_vld & ~flush_i;
    assign head        = fifo_dout[grant_id];
    assign head_rd_en  = head[EN_BIT];
    assign head_rd_idx = head[IDX_LSB +: REG_IDX_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= SRC_W'(NUM_SRC - 1);
            wb_valid_o    <= 1'b0;
            wb_rd_en_o    <= 1'b0;
            wb_pc_o       <= '0;
            wb_rd_idx_o   <= '0;
            wb_rd_wdata_o <= '0;
            wb_src_o      <= '0;
        end else if (grant_fire) begin
            rr_ptr        <= grant_id;
            wb_valid_o    <= 1'b1;
            // x0 writes still retire, they just never reach the regfile.
            wb_rd_en_o    <= head_rd_en & (head_rd_idx != '0);
            wb_pc_o       <= head[PC_LSB +: PC_WIDTH];
            wb_rd_idx_o   <= head_rd_idx;
            wb_rd_wdata_o <= head[WDATA_LSB +: XLEN];
            wb_src_o      <= grant_id;
        end else begin
            wb_valid_o    <= 1'b0;
            wb_rd_en_o    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts every retire
// (cycle, source, fields); an independent monitor compares whatever the DUT presents.
module tb_wb_arbiter;

    localparam int NS    = 2;
    localparam int DEPTH = 2;
    localparam int XL    = 32;
    localparam int RI    = 5;
    localparam int PW    = 32;

    typedef struct packed {
        logic [PW-1:0] pc;
        logic          en;
        logic [RI-1:0] idx;
        logic [XL-1:0] data;
    } ent_t;

    typedef struct {
        int   cyc;
        int   src;
        ent_t e;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    logic [NS-1:0]    src_valid;
    logic [NS-1:0]    src_ready;
    logic [NS*PW-1:0] src_pc;
    logic [NS-1:0]    src_rd_en;
    logic [NS*RI-1:0] src_rd_idx;
    logic [NS*XL-1:0] src_rd_wdata;
    logic             wb_valid;
    logic [PW-1:0]    wb_pc;
    logic             wb_rd_en;
    logic [RI-1:0]    wb_rd_idx;
    logic [XL-1:0]    wb_rd_wdata;
    logic [0:0]       wb_src;

    logic [NS-1:0] pend_v = '0;
    ent_t          pend_e [NS];
    logic [NS-1:0] acc = '0;

    ent_t mq [NS][$];
    exp_t expq[$];
    int   rr = NS - 1;
    int   cyc = 0;
    int   ncmp = 0;
    int   nbad = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .NUM_SRC       (NS),
        .FIFO_DEPTH    (DEPTH),
        .XLEN          (XL),
        .REG_IDX_WIDTH (RI),
        .PC_WIDTH      (PW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush),
        .src_valid_i    (src_valid),
        .src_ready_o    (src_ready),
        .src_pc_i       (src_pc),
        .src_rd_en_i    (src_rd_en),
        .src_rd_idx_i   (src_rd_idx),
        .src_rd_wdata_i (src_rd_wdata),
        .wb_valid_o     (wb_valid),
        .wb_pc_o        (wb_pc),
        .wb_rd_en_o     (wb_rd_en),
        .wb_rd_idx_o    (wb_rd_idx),
        .wb_rd_wdata_o  (wb_rd_wdata),
        .wb_src_o       (wb_src)
    );

    always_comb begin
        src_valid    = pend_v;
        src_pc       = '0;
        src_rd_en    = '0;
        src_rd_idx   = '0;
        src_rd_wdata = '0;
        for (int k = 0; k < NS; k++) begin
            src_pc[k*PW +: PW]       = pend_e[k].pc;
            src_rd_en[k]             = pend_e[k].en;
            src_rd_idx[k*RI +: RI]   = pend_e[k].idx;
            src_rd_wdata[k*XL +: XL] = pend_e[k].data;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        ncmp++;
        if (act !== want) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Reference model: FIFOs are plain queues; one grant per edge in rotating priority.
    task automatic model_step();
        int   sz [NS];
        int   g;
        bit   found;
        exp_t x;
        ent_t e;
        acc = '0;
        if (!rst_n) return;
        for (int k = 0; k < NS; k++) sz[k] = mq[k].size();
        if (flush) begin
            for (int k = 0; k < NS; k++) mq[k].delete();
            return;
        end
        found = 0;
        g = 0;
        for (int i = 1; i <= NS; i++) begin
            if (!found && sz[(rr + i) % NS] > 0) begin
                found = 1;
                g = (rr + i) % NS;
            end
        end
        if (found) begin
            e = mq[g].pop_front();
            x.cyc = cyc;
            x.src = g;
            x.e = e;
            x.e.en = e.en && (e.idx != 0);
            expq.push_back(x);
            rr = g;
        end
        for (int k = 0; k < NS; k++) begin
            if (pend_v[k] && sz[k] != DEPTH) begin
                mq[k].push_back(pend_e[k]);
                acc[k] = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        model_step();
    end

    // Monitor: checks ready every cycle and compares each retire against the scoreboard.
    initial forever begin
        exp_t x;
        @(negedge clk);
        for (int k = 0; k < NS; k++)
            chk($sformatf("src_ready[%0d]", k), 64'(src_ready[k]), 64'(mq[k].size() != DEPTH));
        while (expq.size() > 0 && expq[0].cyc < cyc) begin
            x = expq.pop_front();
            ncmp++;
            nbad++;
            $display("FAIL missing_retire: got none, expected src %0d pc %0h due cycle %0d", x.src, x.e.pc, x.cyc);
        end
        if (wb_valid) begin
            if (expq.size() == 0 || expq[0].cyc != cyc) begin
                ncmp++;
                nbad++;
                $display("FAIL unexpected_retire: got src %0d pc %0h, expected no retire (cycle %0d)", wb_src, wb_pc, cyc);
            end else begin
                x = expq.pop_front();
                chk("wb_src", 64'(wb_src), 64'(x.src));
                chk("wb_pc", 64'(wb_pc), 64'(x.e.pc));
                chk("wb_rd_en", 64'(wb_rd_en), 64'(x.e.en));
                chk("wb_rd_idx", 64'(wb_rd_idx), 64'(x.e.idx));
                chk("wb_rd_wdata", 64'(wb_rd_wdata), 64'(x.e.data));
            end
        end else begin
            chk("idle_rd_en", 64'(wb_rd_en), 64'd0);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
        for (int k = 0; k < NS; k++)
            if (acc[k]) pend_v[k] = 1'b0;
    endtask

    task automatic offer(input int k, input ent_t e);
        pend_e[k] = e;
        pend_v[k] = 1'b1;
    endtask

    function automatic ent_t rnd_ent();
        ent_t e;
        e.pc   = $urandom() & 32'hFFFF_FFFC;
        e.en   = ($urandom_range(0, 3) != 0);
        e.idx  = RI'($urandom_range(0, 31));
        e.data = $urandom();
        return e;
    endfunction

    function automatic ent_t mk(input logic [31:0] pc, input logic en, input logic [4:0] idx,
                                input logic [31:0] d);
        ent_t e;
        e.pc = pc;
        e.en = en;
        e.idx = idx;
        e.data = d;
        return e;
    endfunction

    task automatic do_reset(input int n);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        pend_v = '0;
        flush = 1'b0;
        for (int k = 0; k < NS; k++) mq[k].delete();
        expq.delete();
        rr = NS - 1;
        #1;
        chk("rst_valid", 64'(wb_valid), 64'd0);
        chk("rst_rd_en", 64'(wb_rd_en), 64'd0);
        chk("rst_pc", 64'(wb_pc), 64'd0);
        chk("rst_idx", 64'(wb_rd_idx), 64'd0);
        chk("rst_wdata", 64'(wb_rd_wdata), 64'd0);
        chk("rst_src", 64'(wb_src), 64'd0);
        chk("rst_ready", 64'(src_ready), 64'h3);
        repeat (n) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            step();
            done = (pend_v == '0) && (expq.size() == 0)
                   && (mq[0].size() == 0) && (mq[1].size() == 0);
        end
        if (!done) begin
            ncmp++;
            nbad++;
            $display("FAIL drain_timeout: got %0d pending retires, expected 0", expq.size());
        end
    endtask

    task automatic wait_acc(input int k);
        for (int i = 0; i < 20 && pend_v[k]; i++) step();
        if (pend_v[k]) begin
            ncmp++;
            nbad++;
            $display("FAIL accept_timeout: got src %0d still pending, expected accepted", k);
        end
    endtask

    initial begin
        for (int k = 0; k < NS; k++) pend_e[k] = '0;
        do_reset(3);

        // traffic, then reset in the middle of it
        for (int c = 0; c < 10; c++) begin
            step();
            for (int k = 0; k < NS; k++)
                if (!pend_v[k] && $urandom_range(0, 9) < 7) offer(k, rnd_ent());
        end
        do_reset(3);
        repeat (4) step();

        // single uncontended push on source 1
        step();
        offer(1, mk(32'h8000_0010, 1'b1, 5'd5, 32'hDEAD_BEEF));
        repeat (4) step();

        // contention: both sources offer every cycle
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < NS; k++)
                if (!pend_v[k]) offer(k, rnd_ent());
            step();
        end
        drain();

        // x0 write and non-writing entry
        offer(0, mk(32'h0000_1000, 1'b1, 5'd0, 32'h0000_1234));
        wait_acc(0);
        offer(0, mk(32'h0000_1004, 1'b0, 5'd7, 32'h0000_5678));
        wait_acc(0);
        drain();

        // flush with three buffered entries and a simultaneous push
        offer(0, rnd_ent());
        offer(1, rnd_ent());
        step();
        offer(0, rnd_ent());
        offer(1, rnd_ent());
        step();
        flush = 1'b1;
        offer(0, rnd_ent());
        step();
        flush = 1'b0;
        pend_v = '0;
        chk("flush_valid", 64'(wb_valid), 64'd0);
        chk("flush_rd_en", 64'(wb_rd_en), 64'd0);
        step();
        offer(1, mk(32'h0000_2000, 1'b1, 5'd9, 32'hCAFE_F00D));
        drain();

        // randomized soak with occasional flushes
        for (int c = 0; c < 3000; c++) begin
            step();
            flush = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < NS; k++)
                if (!pend_v[k] && $urandom_range(0, 99) < 60) offer(k, rnd_ent());
        end
        step();
        flush = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
